// File: rtl/apb_master.sv
// APB initiator: turns a valid/ready request into one APB SETUP/ACCESS
// transfer and returns a single-cycle response pulse.
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES wait cycles, which returns rsp_error=1.
module apb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic        req_write,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_error,
    output logic [15:0] apb_paddr,
    output logic [7:0]  apb_pwdata,
    output logic        apb_pwrite,
    output logic        apb_psel,
    output logic        apb_penable,
    input  logic [7:0]  apb_prdata,
    input  logic        apb_pready
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // An out-of-range timeout would silently truncate the 16-bit counter.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t      state_q, state_d;
    logic [15:0] paddr_q, paddr_d;
    logic [7:0]  pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;

`ifdef APB_MASTER_TIMEOUT_EN
    // The abort fires in the ACCESS cycle whose wait would make the count
    // reach TIMEOUT_CYCLES, so compare against the value one below it.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic        rsp_error_q, rsp_error_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Requests are only taken while no transfer is in flight.
    assign req_ready   = (state_q == IDLE);

    assign apb_paddr   = paddr_q;
    assign apb_pwdata  = pwdata_q;
    assign apb_pwrite  = pwrite_q;
    assign apb_psel    = psel_q;
    assign apb_penable = penable_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
    assign rsp_error   = rsp_error_q;
`else
    assign rsp_error   = 1'b0;
`endif

    // Next-state and next-output logic for the IDLE/SETUP/ACCESS sequence.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef APB_MASTER_TIMEOUT_EN
        rsp_error_d = rsp_error_q;
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d   = req_addr;
                    pwdata_d  = req_wdata;
                    pwrite_d  = req_write;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                tmo_cnt_d = 16'd0;
`endif
            end
            ACCESS: begin
                if (apb_pready) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? 8'h00 : apb_prdata;
                    state_d     = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_error_d = 1'b0;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 8'h00;
                    rsp_error_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    tmo_cnt_d   = tmo_cnt_q + 16'd1;
`endif
                end
            end
            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transfer in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            paddr_q     <= 16'h0000;
            pwdata_q    <= 8'h00;
            pwrite_q    <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_error_q <= 1'b0;
            tmo_cnt_q   <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef APB_MASTER_TIMEOUT_EN
            rsp_error_q <= rsp_error_d;
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: a driver issues requests and queues
// expected responses, an APB target model answers with planned wait states,
// and a monitor pops and compares each response pulse.
// Timeout expectations follow APB_MASTER_TIMEOUT_EN when it is defined.
`timescale 1ns/1ps
module tb_apb_master;

    localparam int TO = 8;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        write;
        int          wait_n;
        logic [7:0]  prdata;
    } plan_t;

    typedef struct {
        logic [7:0] rdata;
        logic       error;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        req_write;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_error;
    logic [15:0] apb_paddr;
    logic [7:0]  apb_pwdata;
    logic        apb_pwrite;
    logic        apb_psel;
    logic        apb_penable;
    logic [7:0]  apb_prdata;
    logic        apb_pready;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    plan_t plan_q[$];
    exp_t  exp_q[$];

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pwrite(apb_pwrite),
        .apb_psel(apb_psel), .apb_penable(apb_penable),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready)
    );

    always #5 clk = ~clk;

    // Free-running edge count used to check response latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour: a transfer waits wait_n cycles unless the timeout
    // (when enabled) runs out first, in which case it aborts with an error.
    function automatic exp_t model(input plan_t p, input int hs);
        exp_t e;
        bit   tmo;
        tmo     = TMO_EN && (p.wait_n >= TO);
        e.error = tmo;
        e.rdata = (tmo || p.write) ? 8'h00 : p.prdata;
        e.cyc   = tmo ? hs + TO + 1 : hs + p.wait_n + 2;
        return e;
    endfunction

    // Presents one request (junk fields while not ready), returns at the
    // SETUP-cycle negedge with the handshake edge count in hs.
    task automatic applyStimulus(input plan_t p, input bit expect_rsp, output int hs);
        int budget;
        budget = 200;
        hs = -1;
        req_valid = 1'b1;
        while (!req_ready) begin
            req_addr  = 16'($urandom);
            req_wdata = 8'($urandom);
            req_write = 1'($urandom);
            @(negedge clk);
            budget--;
            if (budget == 0) begin
                checkOutput("req_ready_wait", 32'(req_ready), 32'd1);
                req_valid = 1'b0;
                return;
            end
        end
        req_addr  = p.addr;
        req_wdata = p.wdata;
        req_write = p.write;
        hs = cyc + 1;
        plan_q.push_back(p);
        if (expect_rsp) exp_q.push_back(model(p, hs));
        @(negedge clk);
        checkOutput("setup_psel", 32'(apb_psel), 32'd1);
        checkOutput("setup_penable", 32'(apb_penable), 32'd0);
        req_valid = 1'b0;
        req_addr  = 16'($urandom);
        req_wdata = 8'($urandom);
        req_write = 1'($urandom);
    endtask

    task automatic drain();
        int budget;
        budget = 100;
        while ((exp_q.size() != 0 || plan_q.size() != 0) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        checkOutput("drain_done", 32'(budget > 0), 32'd1);
    endtask

    // APB target model: follows the plan queue, checks held address/data.
    initial begin
        plan_t cur;
        bit    active;
        int    k;
        active = 1'b0;
        k = 0;
        apb_pready = 1'b0;
        apb_prdata = 8'h00;
        forever begin
            @(negedge clk);
            if (apb_psel && apb_penable) begin
                if (!active) begin
                    checkOutput("access_has_plan", 32'(plan_q.size() != 0), 32'd1);
                    if (plan_q.size() != 0) begin
                        cur = plan_q[0];
                        active = 1'b1;
                        k = 0;
                    end
                end
                if (active) begin
                    k++;
                    checkOutput("access_paddr", 32'(apb_paddr), 32'(cur.addr));
                    checkOutput("access_pwdata", 32'(apb_pwdata), 32'(cur.wdata));
                    checkOutput("access_pwrite", 32'(apb_pwrite), 32'(cur.write));
                    apb_pready = (k == cur.wait_n + 1);
                    apb_prdata = apb_pready ? cur.prdata : 8'($urandom);
                end
            end else begin
                if (active) begin
                    void'(plan_q.pop_front());
                    active = 1'b0;
                end
                if (apb_psel && plan_q.size() != 0) begin
                    checkOutput("setup_paddr", 32'(apb_paddr), 32'(plan_q[0].addr));
                    checkOutput("setup_pwrite", 32'(apb_pwrite), 32'(plan_q[0].write));
                end
                apb_pready = 1'($urandom);
                apb_prdata = 8'($urandom);
            end
        end
    end

    // Response monitor: every pulse must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid) begin
                checkOutput("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    checkOutput("rsp_error", 32'(rsp_error), 32'(e.error));
                    checkOutput("rsp_cycle", 32'(cyc), 32'(e.cyc));
                    checkOutput("rsp_req_ready", 32'(req_ready), 32'd1);
                    checkOutput("rsp_psel_low", 32'(apb_psel), 32'd0);
                end
            end
        end
    end

    // Main sequence: reset, directed cases, random traffic, mid-ACCESS reset.
    initial begin
        plan_t p;
        plan_t dir[6];
        int    hs, hs_prev, gap;
        rst = 1'b1;
        req_valid = 1'b0;
        req_addr = 16'h0;
        req_wdata = 8'h0;
        req_write = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset_psel", 32'(apb_psel), 32'd0);
        checkOutput("reset_penable", 32'(apb_penable), 32'd0);
        checkOutput("reset_paddr", 32'(apb_paddr), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);

        dir[0] = '{addr: 16'h0003, wdata: 8'h00, write: 1'b0, wait_n: 0, prdata: 8'hA5};
        dir[1] = '{addr: 16'h0102, wdata: 8'h5C, write: 1'b1, wait_n: 4, prdata: 8'h77};
        dir[2] = '{addr: 16'h0000, wdata: 8'h01, write: 1'b0, wait_n: 0, prdata: 8'h11};
        dir[3] = '{addr: 16'h0100, wdata: 8'h02, write: 1'b0, wait_n: 0, prdata: 8'h22};
        dir[4] = '{addr: 16'h0200, wdata: 8'h03, write: 1'b0, wait_n: TO - 1, prdata: 8'h3C};
        dir[5] = '{addr: 16'h0201, wdata: 8'h04, write: 1'b0, wait_n: TO, prdata: 8'h4D};

        applyStimulus(dir[0], 1'b1, hs);
        drain();
        applyStimulus(dir[1], 1'b1, hs);
        drain();
        applyStimulus(dir[2], 1'b1, hs_prev);
        applyStimulus(dir[3], 1'b1, hs);
        checkOutput("b2b_spacing", 32'(hs - hs_prev), 32'd3);
        drain();
        applyStimulus(dir[4], 1'b1, hs);
        applyStimulus(dir[5], 1'b1, hs);
        drain();

        for (int i = 0; i < 40; i++) begin
            p.addr   = 16'($urandom);
            p.wdata  = 8'($urandom);
            p.write  = 1'($urandom);
            p.wait_n = int'($urandom_range(0, 10));
            p.prdata = 8'($urandom);
            applyStimulus(p, 1'b1, hs);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(negedge clk);
        end
        drain();

        p = '{addr: 16'hBEEF, wdata: 8'h99, write: 1'b1, wait_n: 100, prdata: 8'h00};
        applyStimulus(p, 1'b0, hs);
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_penable", 32'(apb_penable), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_psel", 32'(apb_psel), 32'd0);
        checkOutput("abort_penable", 32'(apb_penable), 32'd0);
        checkOutput("abort_paddr", 32'(apb_paddr), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
        repeat (3) @(negedge clk);
        drain();

        p = '{addr: 16'h0042, wdata: 8'h00, write: 1'b0, wait_n: 1, prdata: 8'h6E};
        applyStimulus(p, 1'b1, hs);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum ACCESS-phase cycles before abort; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; synchronous, active-high.
REQ-004 SHALL have port req_valid, input, 1: a request is present.
REQ-005 SHALL have port req_ready, output, 1: the block accepts a request this cycle.
REQ-006 SHALL have port req_addr, input, 16: the request address.
REQ-007 SHALL have port req_wdata, input, 8: the write data.
REQ-008 SHALL have port req_write, input, 1: 1 for a write, 0 for a read.
REQ-009 SHALL have port rsp_valid, output, 1: a one-cycle response pulse.
REQ-010 SHALL have port rsp_rdata, output, 8: read data, valid while rsp_valid is 1.
REQ-011 SHALL have port rsp_error, output, 1: timeout abort, valid while rsp_valid is 1.
REQ-012 SHALL have ports apb_paddr (out, 16), apb_pwdata (out, 8), apb_pwrite (out, 1), apb_psel (out, 1), apb_penable (out, 1), apb_prdata (in, 8) and apb_pready (in, 1), forming the APB initiator side.

Function
REQ-013 SHALL implement states IDLE, SETUP and ACCESS; all APB and rsp outputs SHALL be driven from registers.
REQ-014 SHALL drive req_ready = 1 only in IDLE; a handshake SHALL occur when req_valid and req_ready are both 1.
REQ-015 On a handshake, SHALL latch req_addr, req_wdata and req_write into apb_paddr, apb_pwdata and apb_pwrite, then go to SETUP.
REQ-016 In SETUP: psel=1, penable=0, for exactly one cycle, then go to ACCESS.
REQ-017 In ACCESS: psel=1, penable=1; paddr, pwdata and pwrite SHALL be held stable from SETUP until the transfer ends.
REQ-018 In ACCESS with pready=1: capture prdata into rsp_rdata (reads only; writes return 0), set rsp_valid=1 and rsp_error=0 for the next cycle, and go to IDLE.
REQ-019 SHALL drop psel and penable in the cycle after completion.
REQ-020 Latency: handshake at edge N gives SETUP in cycle N+1 and ACCESS from cycle N+2.
  - Zero-wait response: rsp_valid in cycle N+3.
  - Minimum request spacing: 3 cycles.
REQ-021 rsp_valid SHALL be a single-cycle pulse with no backpressure; req_ready SHALL be 1 in the same cycle as rsp_valid.
REQ-022 SHALL ignore apb_pready and apb_prdata outside ACCESS.
REQ-023 SHALL ignore req_* inputs when req_ready=0.
REQ-024 A req_valid held high at response time SHALL be accepted in the rsp_valid cycle.

Reset
REQ-025 On rst=1 at a clock edge, SHALL enter IDLE and clear every output register, regardless of the current state:
  - psel, penable, pwrite, paddr, pwdata = 0;
  - rsp_valid, rsp_rdata, rsp_error = 0;
  - timeout counter = 0.
REQ-026 Reset during SETUP or ACCESS SHALL abort the transfer without producing rsp_valid; psel SHALL be 0 in the cycle after the reset edge.
REQ-027 req_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-028 Macro APB_MASTER_TIMEOUT_EN SHALL enable the ACCESS-phase timeout.
REQ-029 With the macro defined, a counter SHALL do the following:
  - clear on entry to ACCESS and increment each ACCESS cycle with pready=0;
  - when it reaches TIMEOUT_CYCLES, end the transfer: drop psel and penable, set rsp_valid=1, rsp_error=1 and rsp_rdata=0, then go to IDLE;
  - if pready=1 in the same cycle the count reaches TIMEOUT_CYCLES, complete normally with rsp_error=0.
REQ-030 Without the macro, SHALL wait in ACCESS indefinitely, tie rsp_error to 0, and synthesize no counter.

Verification
REQ-031 Zero-wait read: req addr=0x0003, write=0, with pready=1 and prdata=0xA5 in the first ACCESS cycle -> psel 1 for 2 cycles, rsp_valid in cycle N+3, rsp_rdata=0xA5, rsp_error=0.
REQ-032 Write with 4 wait states: addr=0x0102, wdata=0x5C, pready low for 4 ACCESS cycles -> paddr, pwdata and pwrite stable for all 6 psel cycles, one rsp_valid pulse, rsp_rdata=0.
REQ-033 Back-to-back: req_valid held with addr 0x0000 then 0x0100 -> second SETUP starts 1 cycle after the first rsp_valid, psel low exactly 1 cycle between transfers, 2 responses.
REQ-034 Timeout, macro defined, TIMEOUT_CYCLES=8, pready held 0 -> rsp_valid with rsp_error=1 and rsp_rdata=0 after 8 ACCESS cycles, then psel=0 and req_ready=1.
REQ-035 Timeout boundary: pready=1 exactly at the 8th ACCESS cycle -> rsp_error=0 and prdata captured.
REQ-036 Reset mid-ACCESS: rst=1 for 1 cycle while pready=0 -> psel=0 and penable=0 next cycle, no rsp_valid, req_ready=1 after reset.
